tetris_line_clear: RTL and testbench

//  Reader/consumer of the tetris playfield vector: on Start, captures the ROWS x COLS occupancy board,

---
 rtl/tetris_pkg.sv | 25 ++
 rtl/tetris_row_collapse.sv | 30 +++
 rtl/tetris_line_clear.sv | 124 ++++++++++++
 tb/tb_tetris_line_clear.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared definitions for the tetris line-clear block: default board size,
// one-hot state encoding and the lines-to-points table.
package tetris_pkg;

    localparam int ROWS_DEF = 16;
    localparam int COLS_DEF = 10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_SCAN = 3'b010,
        ST_DONE = 3'b100
    } state_t;

    // Points awarded for the number of rows removed in one pass.
    function automatic logic [3:0] pts(input int unsigned n);
        logic [3:0] p;
        if (n == 0)      p = 4'd0;
        else if (n == 1) p = 4'd1;
        else if (n == 2) p = 4'd3;
        else if (n == 3) p = 4'd5;
        else             p = 4'd8;
        return p;
    endfunction

endpackage

// File: rtl/tetris_row_collapse.sv
// Combinational row removal: drops the selected row, shifts every row above
// it down by one and fills the top row with zeros. Also flags whether the
// selected row is completely occupied.
module tetris_row_collapse
    import tetris_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF,
    parameter int PW   = $clog2(ROWS)
) (
    input  logic [ROWS*COLS-1:0] board_in,
    input  logic [PW-1:0]        row,
    output logic [ROWS*COLS-1:0] board_out,
    output logic                 row_full
);

    // Rows below the removed row stay; the removed row and those above take the row above.
    always_comb begin
        board_out = '0;
        row_full  = &board_in[row*COLS +: COLS];
        for (int r = 0; r < ROWS; r++) begin
            if (PW'(r) > row) begin
                board_out[r*COLS +: COLS] = board_in[r*COLS +: COLS];
            end else if (r != 0) begin
                board_out[r*COLS +: COLS] = board_in[(r-1)*COLS +: COLS];
            end
        end
    end

endmodule

// File: rtl/tetris_line_clear.sv
// Line-clear engine: captures the playfield on Start, walks rows bottom-up
// one per cycle, removes full rows (rescanning the same index after each
// removal), then updates a saturating score and waits for Ack.
module tetris_line_clear
    import tetris_pkg::*;
#(
    parameter int  ROWS    = ROWS_DEF,
    parameter int  COLS    = COLS_DEF,
    parameter int  SCORE_W = 16,
    localparam int LW      = $clog2(ROWS+1)
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Start,
    input  logic                 Ack,
    input  logic [ROWS*COLS-1:0] Blocks_in,
    output logic [ROWS*COLS-1:0] Blocks_out,
    output logic [LW-1:0]        Lines,
    output logic [SCORE_W-1:0]   Score,
    output logic                 q_Idle,
    output logic                 q_Scan,
    output logic                 q_Done
);

    localparam int PW = $clog2(ROWS);

    state_t                 state_q, state_d;
    logic [ROWS*COLS-1:0]   board_q, board_d;
    logic [LW-1:0]          lines_q, lines_d;
    logic [SCORE_W-1:0]     score_q, score_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [ROWS*COLS-1:0]   collapsed;
    logic                   row_full;

    // Score accumulation clamps at all-ones instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                   input logic [3:0] p);
        logic [SCORE_W:0] sum;
        sum = {1'b0, s} + {{(SCORE_W-3){1'b0}}, p};
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

    tetris_row_collapse #(
        .ROWS (ROWS),
        .COLS (COLS),
        .PW   (PW)
    ) u_collapse (
        .board_in  (board_q),
        .row       (ptr_q),
        .board_out (collapsed),
        .row_full  (row_full)
    );

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state: leave SCAN only once row 0 has been examined and kept.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (Start) state_d = ST_SCAN;
            ST_SCAN: if (!row_full && ptr_q == '0) state_d = ST_DONE;
            ST_DONE: if (Ack) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: capture, collapse/step, and final scoring.
    always_comb begin
        board_d = board_q;
        lines_d = lines_q;
        score_d = score_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    board_d = Blocks_in;
                    lines_d = '0;
                    ptr_d   = PW'(ROWS-1);
                end
            end
            ST_SCAN: begin
                if (row_full) begin
                    board_d = collapsed;
                    lines_d = lines_q + LW'(1);
                end else if (ptr_q == '0) begin
                    score_d = sat_add(score_q, pts(32'(lines_q)));
                end else begin
                    ptr_d = ptr_q - PW'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            board_q <= '0;
            lines_q <= '0;
            score_q <= '0;
            ptr_q   <= PW'(ROWS-1);
        end else begin
            board_q <= board_d;
            lines_q <= lines_d;
            score_q <= score_d;
            ptr_q   <= ptr_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        q_Idle     = (state_q == ST_IDLE);
        q_Scan     = (state_q == ST_SCAN);
        q_Done     = (state_q == ST_DONE);
        Blocks_out = board_q;
        Lines      = lines_q;
        Score      = score_q;
    end

endmodule

// File: tb/tb_tetris_line_clear.sv
// Bench for tetris_line_clear: directed and random boards against a
// compaction-based reference model; a second instance with a 4-bit score
// exercises saturation.
module tb_tetris_line_clear;

    localparam int ROWS = 16;
    localparam int COLS = 10;
    localparam int N    = ROWS*COLS;
    localparam int LW   = $clog2(ROWS+1);

    logic         Clk = 1'b0;
    logic         Reset_n, Start, Ack;
    logic [N-1:0] Blocks_in;

    logic [N-1:0]  a_blocks, b_blocks;
    logic [LW-1:0] a_lines, b_lines;
    logic [15:0]   a_score;
    logic [3:0]    b_score;
    logic          a_idle, a_scan, a_done, b_idle, b_scan, b_done;

    int checks = 0;
    int errors = 0;
    int exp_s16 = 0;
    int exp_s4  = 0;

    tetris_line_clear #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(16)) u_a (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Ack(Ack), .Blocks_in(Blocks_in),
        .Blocks_out(a_blocks), .Lines(a_lines), .Score(a_score),
        .q_Idle(a_idle), .q_Scan(a_scan), .q_Done(a_done)
    );

    tetris_line_clear #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(4)) u_b (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Ack(Ack), .Blocks_in(Blocks_in),
        .Blocks_out(b_blocks), .Lines(b_lines), .Score(b_score),
        .q_Idle(b_idle), .q_Scan(b_scan), .q_Done(b_done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pts_ref(input int n);
        if (n >= 4) return 8;
        return (n == 0) ? 0 : 2*n - 1;
    endfunction

    // Reference: keep non-full rows in order, packed to the bottom, zeros on top.
    task automatic model(input logic [N-1:0] b, output logic [N-1:0] out, output int lines);
        int k;
        logic [COLS-1:0] row;
        out   = '0;
        lines = 0;
        k     = ROWS-1;
        for (int r = ROWS-1; r >= 0; r--) begin
            row = b[r*COLS +: COLS];
            if (row == {COLS{1'b1}}) lines++;
            else begin
                out[k*COLS +: COLS] = row;
                k--;
            end
        end
    endtask

    function automatic logic [N-1:0] rand_vec();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [N-1:0] rand_board();
        logic [N-1:0] b;
        b = rand_vec();
        for (int r = 0; r < ROWS; r++) begin
            case ($urandom % 4)
                0, 1: b[r*COLS +: COLS] = '1;
                2:    b[r*COLS +: COLS] = '0;
                default: ;
            endcase
        end
        return b;
    endfunction

    task automatic do_reset(input string tag);
        Reset_n = 1'b0;
        #1;
        chk({tag, ":idle"},   N'(a_idle), N'(1));
        chk({tag, ":scan"},   N'(a_scan), N'(0));
        chk({tag, ":blocks"}, a_blocks, '0);
        chk({tag, ":lines"},  N'(a_lines), '0);
        chk({tag, ":score"},  N'(a_score), '0);
        chk({tag, ":score4"}, N'(b_score), '0);
        exp_s16 = 0;
        exp_s4  = 0;
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic run_pass(input logic [N-1:0] b, input bit noise, input string tag);
        logic [N-1:0] eb;
        int el, cyc;
        model(b, eb, el);
        @(negedge Clk);
        Blocks_in = b;
        Start     = 1'b1;
        Ack       = 1'b0;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        chk({tag, ":scan"}, N'(a_scan), N'(1));
        cyc = 0;
        while (!a_done && cyc < 2*ROWS + 4) begin
            if (noise) begin
                Blocks_in = rand_vec();
                Start     = 1'($urandom % 2);
                Ack       = 1'($urandom % 2);
            end
            @(posedge Clk);
            #1;
            cyc++;
        end
        Start     = 1'b0;
        Ack       = 1'b0;
        Blocks_in = rand_vec();
        exp_s16 = exp_s16 + pts_ref(el);
        if (exp_s16 > 65535) exp_s16 = 65535;
        exp_s4 = exp_s4 + pts_ref(el);
        if (exp_s4 > 15) exp_s4 = 15;
        chk({tag, ":cycles"}, N'(cyc), N'(ROWS + el));
        chk({tag, ":done"},   N'(a_done), N'(1));
        chk({tag, ":blocks"}, a_blocks, eb);
        chk({tag, ":lines"},  N'(a_lines), N'(el));
        chk({tag, ":score"},  N'(a_score), N'(exp_s16));
        chk({tag, ":score4"}, N'(b_score), N'(exp_s4));
        chk({tag, ":done4"},  N'(b_done), N'(1));
        // DONE holds under Start, then Ack with Start releases without recapture.
        Start = 1'b1;
        @(posedge Clk);
        #1;
        chk({tag, ":hold"},     N'(a_done), N'(1));
        chk({tag, ":holdblk"},  a_blocks, eb);
        Ack = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        Ack   = 1'b0;
        chk({tag, ":ackidle"}, N'(a_idle), N'(1));
        @(posedge Clk);
        #1;
        chk({tag, ":stayidle"}, N'(a_idle), N'(1));
        chk({tag, ":keeplines"}, N'(a_lines), N'(el));
        chk({tag, ":keepscore"}, N'(a_score), N'(exp_s16));
    endtask

    initial begin
        logic [N-1:0] b;
        Reset_n   = 1'b1;
        Start     = 1'b0;
        Ack       = 1'b0;
        Blocks_in = '0;
        #12;
        do_reset("rst0");

        run_pass('0, 1'b0, "empty");

        b = '0;
        b[159:150] = '1;
        b[140] = 1'b1;
        run_pass(b, 1'b0, "one_line");

        b = '0;
        b[15*COLS +: COLS] = '1;
        b[14*COLS +: COLS] = '1;
        b[13*COLS +: COLS] = 10'h001;
        b[12*COLS +: COLS] = '1;
        b[11*COLS +: COLS] = '1;
        run_pass(b, 1'b0, "four_lines");

        run_pass('1, 1'b0, "all_ones_a");
        run_pass('1, 1'b0, "all_ones_b");

        run_pass(rand_board(), 1'b1, "noise");

        // Abort mid-scan, then a normal pass afterwards.
        @(negedge Clk);
        Blocks_in = '1;
        Start     = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (5) @(posedge Clk);
        #2;
        do_reset("rst_mid");
        run_pass(rand_board(), 1'b0, "after_rst");

        for (int i = 0; i < 12; i++) begin
            run_pass(rand_board(), 1'($urandom % 2), $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
